// File: rtl/pcierc_pkg.sv
// Shared encodings for the PCIe root-complex VC0 transmit path.
package pcierc_pkg;

  typedef enum logic [1:0] {
    CLS_P   = 2'd0,
    CLS_NP  = 2'd1,
    CLS_CPL = 2'd2,
    CLS_ILL = 2'd3
  } tlp_class_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    REQ    = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } tx_state_e;

  localparam int HDR_INF_BIT = 8;
  localparam int DAT_INF_BIT = 12;
  localparam int MAX_DW_DEF  = 1024;

  // Data credits are 4-DW units; round the payload length up.
  function automatic logic [11:0] dw_to_credits(input logic [10:0] dw);
    return ({1'b0, dw} + 12'd3) >> 2;
  endfunction

endpackage

// File: rtl/pcierc_credit_chk.sv
// Selects the header/data credit pair for a TLP class and checks it covers
// one header plus need_d data credits.
module pcierc_credit_chk
  import pcierc_pkg::*;
(
  input  logic [1:0]  cls,
  input  logic [11:0] need_d,
  input  logic [8:0]  ca_ph,
  input  logic [8:0]  ca_nph,
  input  logic [8:0]  ca_cplh,
  input  logic [12:0] ca_pd,
  input  logic [12:0] ca_npd,
  input  logic [12:0] ca_cpld,
  output logic        pass
);

  logic [8:0]  hdr [3];
  logic [12:0] dat [3];
  logic [2:0]  pass_vec;

  assign hdr[0] = ca_ph;
  assign hdr[1] = ca_nph;
  assign hdr[2] = ca_cplh;
  assign dat[0] = ca_pd;
  assign dat[1] = ca_npd;
  assign dat[2] = ca_cpld;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cls
      logic hdr_ok;
      logic dat_ok;
      // need_d of zero always satisfies the unsigned compare
      assign hdr_ok = hdr[gi][HDR_INF_BIT] | (hdr[gi][7:0] != 8'd0);
      assign dat_ok = dat[gi][DAT_INF_BIT] | (dat[gi][11:0] >= need_d);
      assign pass_vec[gi] = hdr_ok & dat_ok;
    end
  endgenerate

  always_comb begin
    pass = 1'b0;
    case (cls)
      CLS_P:   pass = pass_vec[0];
      CLS_NP:  pass = pass_vec[1];
      CLS_CPL: pass = pass_vec[2];
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/pcierc_tx_tlp_sender.sv
// VC0 transmit engine: credit-gates one descriptor + word stream per TLP and
// drives the core TX port with a one-cycle registered data path.
module pcierc_tx_tlp_sender
  import pcierc_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int MAX_DW = MAX_DW_DEF
)(
  input  logic             sys_clk_125,
  input  logic             rst_n,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  logic [1:0]       desc_class,
  input  logic [10:0]      desc_dw,
  input  logic [15:0]      s_data,
  input  logic             s_valid,
  input  logic             s_last,
  input  logic             s_nlfy,
  output logic             s_ready,
  output logic             tx_req_vc0,
  input  logic             tx_rdy_vc0,
  output logic [15:0]      tx_data_vc0,
  output logic             tx_st_vc0,
  output logic             tx_end_vc0,
  output logic             tx_nlfy_vc0,
  input  logic [8:0]       tx_ca_ph_vc0,
  input  logic [8:0]       tx_ca_nph_vc0,
  input  logic [8:0]       tx_ca_cplh_vc0,
  input  logic [12:0]      tx_ca_pd_vc0,
  input  logic [12:0]      tx_ca_npd_vc0,
  input  logic [12:0]      tx_ca_cpld_vc0,
  output logic [CNT_W-1:0] tlp_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err_underrun,
  output logic             err_desc
);

  tx_state_e        state_reg, state_next;
  logic [1:0]       cls_reg;
  logic [11:0]      need_d_reg;
  logic             credit_pass;
  logic             desc_bad;
  logic             word_take;
  logic [15:0]      data_reg;
  logic             st_reg, end_reg, nlfy_reg;
  logic [CNT_W-1:0] tlp_cnt_reg, stall_cnt_reg;
  logic             err_underrun_reg, err_desc_reg;

  assign desc_bad = (desc_class == CLS_ILL) || ({21'd0, desc_dw} > 32'(MAX_DW));

  pcierc_credit_chk u_credit_chk (
    .cls     (cls_reg),
    .need_d  (need_d_reg),
    .ca_ph   (tx_ca_ph_vc0),
    .ca_nph  (tx_ca_nph_vc0),
    .ca_cplh (tx_ca_cplh_vc0),
    .ca_pd   (tx_ca_pd_vc0),
    .ca_npd  (tx_ca_npd_vc0),
    .ca_cpld (tx_ca_cpld_vc0),
    .pass    (credit_pass)
  );

  always_ff @(posedge sys_clk_125 or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // A descriptor is never taken while tx_end is on the wire, so the next TLP
  // starts no earlier than the cycle after the previous one ends.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (desc_valid && !end_reg) state_next = desc_bad ? DRAIN : CHECK;
      CHECK:  if (credit_pass && s_valid) state_next = REQ;
      REQ:    if (tx_rdy_vc0 && s_valid) state_next = s_last ? IDLE : STREAM;
      STREAM: begin
        if (!s_valid)    state_next = DRAIN;
        else if (s_last) state_next = IDLE;
      end
      DRAIN:  if (s_valid && s_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    desc_ready = 1'b0;
    s_ready    = 1'b0;
    tx_req_vc0 = 1'b0;
    case (state_reg)
      IDLE:          desc_ready = desc_valid && !end_reg;
      REQ: begin
        tx_req_vc0 = 1'b1;
        s_ready    = tx_rdy_vc0;
      end
      STREAM, DRAIN: s_ready = 1'b1;
      default: ;
    endcase
  end

  assign word_take = s_valid && ((state_reg == REQ && tx_rdy_vc0) || state_reg == STREAM);

  always_ff @(posedge sys_clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      cls_reg          <= 2'd0;
      need_d_reg       <= 12'd0;
      data_reg         <= 16'd0;
      st_reg           <= 1'b0;
      end_reg          <= 1'b0;
      nlfy_reg         <= 1'b0;
      tlp_cnt_reg      <= '0;
      stall_cnt_reg    <= '0;
      err_underrun_reg <= 1'b0;
      err_desc_reg     <= 1'b0;
    end else begin
      data_reg <= 16'd0;
      st_reg   <= 1'b0;
      end_reg  <= 1'b0;
      nlfy_reg <= 1'b0;

      if (desc_ready) begin
        cls_reg    <= desc_class;
        need_d_reg <= dw_to_credits(desc_dw);
        if (desc_bad) err_desc_reg <= 1'b1;
      end

      if (state_reg == CHECK && !credit_pass && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);

      if (word_take) begin
        data_reg <= s_data;
        st_reg   <= (state_reg == REQ);
        end_reg  <= s_last;
        nlfy_reg <= s_last & s_nlfy;
        if (s_last) tlp_cnt_reg <= tlp_cnt_reg + CNT_W'(1);
      end else if (state_reg == STREAM) begin
        // Upstream ran dry mid-packet: close it out as a nullified TLP.
        end_reg          <= 1'b1;
        nlfy_reg         <= 1'b1;
        err_underrun_reg <= 1'b1;
      end
    end
  end

  assign tx_data_vc0  = data_reg;
  assign tx_st_vc0    = st_reg;
  assign tx_end_vc0   = end_reg;
  assign tx_nlfy_vc0  = nlfy_reg;
  assign tlp_cnt      = tlp_cnt_reg;
  assign stall_cnt    = stall_cnt_reg;
  assign err_underrun = err_underrun_reg;
  assign err_desc     = err_desc_reg;

endmodule

// File: tb/tb_pcierc_tx_tlp_sender.sv
// Directed bench for pcierc_tx_tlp_sender: scoreboard of expected TX beats,
// a simple core model granting tx_rdy, and counter/error checks.
module tb_pcierc_tx_tlp_sender;

  typedef struct packed {
    logic [15:0] data;
    logic        st;
    logic        en;
    logic        nl;
  } beat_t;

  logic        sys_clk_125 = 1'b0;
  logic        rst_n = 1'b1;
  logic        desc_valid;
  logic        desc_ready;
  logic [1:0]  desc_class;
  logic [10:0] desc_dw;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_nlfy;
  logic        s_ready;
  logic        tx_req_vc0;
  logic        tx_rdy_vc0;
  logic [15:0] tx_data_vc0;
  logic        tx_st_vc0;
  logic        tx_end_vc0;
  logic        tx_nlfy_vc0;
  logic [8:0]  ca_ph, ca_nph, ca_cplh;
  logic [12:0] ca_pd, ca_npd, ca_cpld;
  logic [15:0] tlp_cnt;
  logic [15:0] stall_cnt;
  logic        err_underrun;
  logic        err_desc;

  int    tests_run = 0;
  int    tests_failed = 0;
  beat_t exp_q[$];
  bit    mon_en = 1'b1;
  int    req_cycles = 0;
  int    exp_tlp = 0;

  always #4 sys_clk_125 = ~sys_clk_125;

  pcierc_tx_tlp_sender dut (
    .sys_clk_125    (sys_clk_125),
    .rst_n          (rst_n),
    .desc_valid     (desc_valid),
    .desc_ready     (desc_ready),
    .desc_class     (desc_class),
    .desc_dw        (desc_dw),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_nlfy         (s_nlfy),
    .s_ready        (s_ready),
    .tx_req_vc0     (tx_req_vc0),
    .tx_rdy_vc0     (tx_rdy_vc0),
    .tx_data_vc0    (tx_data_vc0),
    .tx_st_vc0      (tx_st_vc0),
    .tx_end_vc0     (tx_end_vc0),
    .tx_nlfy_vc0    (tx_nlfy_vc0),
    .tx_ca_ph_vc0   (ca_ph),
    .tx_ca_nph_vc0  (ca_nph),
    .tx_ca_cplh_vc0 (ca_cplh),
    .tx_ca_pd_vc0   (ca_pd),
    .tx_ca_npd_vc0  (ca_npd),
    .tx_ca_cpld_vc0 (ca_cpld),
    .tlp_cnt        (tlp_cnt),
    .stall_cnt      (stall_cnt),
    .err_underrun   (err_underrun),
    .err_desc       (err_desc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] out_bundle();
    return {8'd0, desc_ready, s_ready, tx_req_vc0, tx_data_vc0, tx_st_vc0,
            tx_end_vc0, tx_nlfy_vc0, tlp_cnt, stall_cnt, err_underrun, err_desc};
  endfunction

  task automatic settle(input int n);
    repeat (n) @(negedge sys_clk_125);
  endtask

  task automatic send_desc(input logic [1:0] cls, input logic [10:0] dw);
    int guard;
    guard = 0;
    desc_valid = 1'b1;
    desc_class = cls;
    desc_dw    = dw;
    #1;
    while (!desc_ready && guard < 400) begin
      @(negedge sys_clk_125);
      #1;
      guard++;
    end
    if (guard >= 400) check("desc_accept_timeout", 64'(desc_ready), 64'd1);
    @(negedge sys_clk_125);
    desc_valid = 1'b0;
    $display("[TB] descriptor class=%0d dw=%0d accepted at %0t", cls, dw, $time);
  endtask

  task automatic push_word(input logic [15:0] d, input bit last, input bit nl,
                           input bit send, input bit first);
    int guard;
    guard = 0;
    s_data  = d;
    s_last  = last;
    s_nlfy  = nl;
    s_valid = 1'b1;
    if (send) exp_q.push_back(beat_t'{d, first, last, last & nl});
    #1;
    while (!s_ready && guard < 400) begin
      @(negedge sys_clk_125);
      #1;
      guard++;
    end
    if (guard >= 400) check("word_accept_timeout", 64'(s_ready), 64'd1);
    @(negedge sys_clk_125);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_nlfy  = 1'b0;
  endtask

  task automatic send_tlp(input int n, input logic [15:0] base, input bit nl, input bit send);
    for (int i = 0; i < n; i++)
      push_word(base + 16'(i), (i == n - 1), nl, send, (i == 0));
  endtask

  // Core model: grants a few cycles after tx_req, holds tx_rdy until tx_end.
  initial begin
    int gcnt;
    gcnt = 0;
    tx_rdy_vc0 = 1'b0;
    forever begin
      @(negedge sys_clk_125);
      if (!rst_n) begin
        tx_rdy_vc0 = 1'b0;
        gcnt = 0;
      end else if (tx_rdy_vc0) begin
        if (tx_end_vc0) tx_rdy_vc0 = 1'b0;
      end else if (tx_req_vc0) begin
        gcnt++;
        if (gcnt >= 3) begin
          tx_rdy_vc0 = 1'b1;
          gcnt = 0;
        end
      end
    end
  end

  // Output monitor: every packet cycle pops one expected beat.
  initial begin
    bit    in_pkt;
    bit    prev_grant;
    beat_t obs;
    beat_t exp;
    in_pkt = 1'b0;
    prev_grant = 1'b0;
    forever begin
      @(negedge sys_clk_125);
      #1;
      if (!rst_n) begin
        in_pkt = 1'b0;
        prev_grant = 1'b0;
      end else begin
        if (tx_req_vc0) req_cycles++;
        if (mon_en) begin
          if (tx_st_vc0 || tx_end_vc0 || in_pkt) begin
            obs = {tx_data_vc0, tx_st_vc0, tx_end_vc0, tx_nlfy_vc0};
            if (exp_q.size() == 0) begin
              check("sb_beat_expected", 64'(exp_q.size()), 64'd1);
            end else begin
              exp = exp_q.pop_front();
              check("sb_beat", 64'(obs), 64'(exp));
              $display("[TB] beat data=%h st=%0b end=%0b nlfy=%0b at %0t",
                       tx_data_vc0, tx_st_vc0, tx_end_vc0, tx_nlfy_vc0, $time);
            end
            if (tx_st_vc0) check("st_after_grant", 64'(prev_grant), 64'd1);
            in_pkt = !tx_end_vc0;
          end else begin
            check("idle_quiet", 64'({tx_data_vc0, tx_nlfy_vc0}), 64'd0);
          end
        end
        prev_grant = tx_req_vc0 && tx_rdy_vc0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    desc_valid = 1'b0; desc_class = 2'd0; desc_dw = 11'd0;
    s_data = 16'd0; s_valid = 1'b0; s_last = 1'b0; s_nlfy = 1'b0;
    ca_ph = 9'd8; ca_nph = 9'd8; ca_cplh = 9'd8;
    ca_pd = 13'd64; ca_npd = 13'd64; ca_cpld = 13'd64;

    #2 rst_n = 1'b0;
    settle(3);
    check("reset_outputs", out_bundle(), 64'd0);
    rst_n = 1'b1;
    settle(1);

    // Posted write, 12 words, ph=5 pd=2, need_d=1
    ca_ph = 9'd5; ca_pd = 13'd2;
    send_desc(2'd0, 11'd4);
    send_tlp(12, 16'h1000, 1'b0, 1'b1);
    settle(4);
    exp_tlp = 1;
    check("t1_tlp_cnt", 64'(tlp_cnt), 64'(exp_tlp));
    check("t1_stall_cnt", 64'(stall_cnt), 64'd0);

    // Infinite data credit with maximum legal length
    ca_pd = 13'h1000;
    send_desc(2'd0, 11'd1024);
    send_tlp(4, 16'h4000, 1'b0, 1'b1);
    settle(4);
    exp_tlp = 2;
    check("t4_stall_cnt", 64'(stall_cnt), 64'd0);
    check("t4_tlp_cnt", 64'(tlp_cnt), 64'(exp_tlp));
    check("t4_err_desc", 64'(err_desc), 64'd0);

    // Non-posted read, no payload, npd=0; last word nullified
    ca_nph = 9'd1; ca_npd = 13'd0;
    send_desc(2'd1, 11'd0);
    send_tlp(6, 16'h3000, 1'b1, 1'b1);
    settle(4);
    exp_tlp = 3;
    check("t3_tlp_cnt", 64'(tlp_cnt), 64'(exp_tlp));
    check("t3_stall_cnt", 64'(stall_cnt), 64'd0);

    // Completion blocked 50 cycles on cpld=2 (needs 3)
    ca_cpld = 13'd2;
    req_cycles = 0;
    send_desc(2'd2, 11'd9);
    fork
      send_tlp(7, 16'h2000, 1'b0, 1'b1);
      begin
        settle(50);
        check("t2_blocked_req", 64'(req_cycles), 64'd0);
        check("t2_stall_at_50", 64'(stall_cnt), 64'd50);
        ca_cpld = 13'd3;
      end
    join
    settle(4);
    exp_tlp = 4;
    check("t2_stall_final", 64'(stall_cnt), 64'd50);
    check("t2_tlp_cnt", 64'(tlp_cnt), 64'(exp_tlp));

    // Underrun: s_valid drops before word 5 of 10
    send_desc(2'd0, 11'd2);
    for (int i = 0; i < 4; i++)
      push_word(16'h5000 + 16'(i), 1'b0, 1'b0, 1'b1, (i == 0));
    exp_q.push_back(beat_t'{16'h0000, 1'b0, 1'b1, 1'b1});
    settle(1);
    for (int i = 4; i < 10; i++)
      push_word(16'h5000 + 16'(i), (i == 9), 1'b0, 1'b0, 1'b0);
    settle(4);
    check("t5_err_underrun", 64'(err_underrun), 64'd1);
    check("t5_tlp_cnt", 64'(tlp_cnt), 64'(exp_tlp));
    check("t5_err_desc", 64'(err_desc), 64'd0);

    // Illegal class is drained without a request
    req_cycles = 0;
    send_desc(2'd3, 11'd4);
    send_tlp(5, 16'h6000, 1'b0, 1'b0);
    settle(4);
    check("t6_err_desc", 64'(err_desc), 64'd1);
    check("t6_no_req", 64'(req_cycles), 64'd0);
    check("t6_tlp_cnt", 64'(tlp_cnt), 64'(exp_tlp));

    // Reset pulsed mid-STREAM clears everything at once
    mon_en = 1'b0;
    send_desc(2'd0, 11'd4);
    s_data = 16'hBEEF; s_last = 1'b0; s_valid = 1'b1;
    guard = 0;
    #1;
    while (!tx_st_vc0 && guard < 100) begin
      @(negedge sys_clk_125);
      #1;
      guard++;
    end
    if (guard >= 100) check("rst_stream_timeout", 64'(tx_st_vc0), 64'd1);
    settle(2);
    check("pre_rst_in_stream", 64'(tx_data_vc0), 64'hBEEF);
    rst_n = 1'b0;
    #1;
    check("mid_stream_reset", out_bundle(), 64'd0);
    s_valid = 1'b0;
    settle(2);
    rst_n = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    exp_tlp = 0;
    settle(1);

    // Oversized payload is rejected
    req_cycles = 0;
    send_desc(2'd0, 11'd1025);
    send_tlp(3, 16'h7000, 1'b0, 1'b0);
    settle(4);
    check("t7_err_desc", 64'(err_desc), 64'd1);
    check("t7_no_req", 64'(req_cycles), 64'd0);

    // Normal traffic still flows after the error
    send_desc(2'd0, 11'd3);
    send_tlp(3, 16'h8000, 1'b0, 1'b1);
    settle(4);
    exp_tlp = 1;
    check("t8_tlp_cnt", 64'(tlp_cnt), 64'(exp_tlp));
    check("t8_err_desc_sticky", 64'(err_desc), 64'd1);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pcierc_tx_tlp_sender.md
Name: pcierc_tx_tlp_sender

Overview:
User-side transmit engine for the PCIe root-complex core's VC0 TX interface. It accepts one descriptor plus a 16-bit word stream per TLP from upstream logic. It gates each TLP on available header and data credits, performs the tx_req/tx_rdy handshake, and drives tx_data/tx_st/tx_end/tx_nlfy into the core. It sits beside the core top in the 125 MHz domain and is the producer for the TX port that the core exposes.

Parameters:
CNT_W, 16, width of the status counters
MAX_DW, 1024, maximum payload length in DW; descriptors above this are rejected

Ports:
sys_clk_125  in  1  core 125 MHz clock; only clock
rst_n  in  1  asynchronous active-low reset
desc_valid  in  1  descriptor valid
desc_ready  out  1  descriptor accepted (1-cycle pulse)
desc_class  in  2  0=posted, 1=non-posted, 2=completion, 3=illegal
desc_dw  in  11  payload length in DW; 0 = no payload
s_data  in  16  TLP word stream, header first
s_valid  in  1  word valid
s_last  in  1  final word of TLP
s_nlfy  in  1  nullify request; sampled with s_last
s_ready  out  1  word accepted
tx_req_vc0  out  1  request to core
tx_rdy_vc0  in  1  grant from core
tx_data_vc0  out  16  data to core
tx_st_vc0  out  1  start of TLP
tx_end_vc0  out  1  end of TLP
tx_nlfy_vc0  out  1  nullify; only with tx_end
tx_ca_ph_vc0, tx_ca_nph_vc0, tx_ca_cplh_vc0  in  9 each  header credits; bit 8 = infinite
tx_ca_pd_vc0, tx_ca_npd_vc0, tx_ca_cpld_vc0  in  13 each  data credits; bit 12 = infinite
tlp_cnt  out  CNT_W  TLPs completed; wraps
stall_cnt  out  CNT_W  cycles spent credit-blocked; saturates at all-ones
err_underrun  out  1  sticky; s_valid dropped mid-TLP
err_desc  out  1  sticky; illegal class or desc_dw > MAX_DW

Behaviour:
- Reset (async, rst_n low): all outputs 0; state IDLE; counters 0; sticky errors cleared. Reset mid-TLP abandons the packet with no tx_end; core reset is concurrent.
- Data-credit requirement: need_d = (desc_dw + 3) >> 2, computed at 12 bits. Header requirement is 1.
- Credit class selected by desc_class: 0 uses ph/pd, 1 uses nph/npd, 2 uses cplh/cpld.
- A credit satisfies the check if its infinite bit is set or its value is >= the requirement. need_d = 0 always passes the data check.
- IDLE: if desc_valid, latch class and need_d, pulse desc_ready, go to CHECK.
  - If class is 3 or desc_dw > MAX_DW: set err_desc, still pulse desc_ready, and go to DRAIN so the packet is discarded.
- CHECK: combinational compare against current tx_ca_* inputs.
  - Pass and s_valid=1: go to REQ.
  - Otherwise: stay in CHECK and increment stall_cnt, but only when the credit compare itself failed.
- REQ: tx_req_vc0=1. s_ready = tx_rdy_vc0.
  - On an edge where tx_rdy_vc0=1: first word is registered to tx_data_vc0 with tx_st_vc0=1 in the next cycle, tx_req_vc0 drops, go to STREAM.
  - If that first word has s_last=1, tx_st and tx_end appear together.
- STREAM: s_ready=1. Each accepted word appears on tx_data_vc0 exactly one cycle later (1-cycle latency).
  - The word accepted with s_last drives tx_end_vc0=1, with tx_nlfy_vc0 = s_nlfy. tlp_cnt increments on that output cycle, then go to IDLE.
  - The core holds tx_rdy high from grant to tx_end; the block never stalls on tx_rdy once in STREAM.
- Underrun: s_valid=0 in STREAM.
  - Next output cycle: tx_end_vc0=1, tx_nlfy_vc0=1, tx_data_vc0=0.
  - Set err_underrun; tlp_cnt is not incremented. Go to DRAIN.
- DRAIN: s_ready=1; discard words through s_last, then go to IDLE. No core outputs are driven.
- Output pulse rules: tx_st, tx_end and tx_nlfy are 1-cycle pulses and are 0 outside packet cycles. tx_data holds 0 when idle.
- Back-to-back: the next descriptor is accepted in the cycle after tx_end at the earliest. There is no overlap of REQ with STREAM.

Decomposition:
- Shared package pcierc_pkg: class encodings (CLS_P, CLS_NP, CLS_CPL), state enum (IDLE, CHECK, REQ, STREAM, DRAIN), infinite-bit positions (8, 12), MAX_DW default.
- One sub-module, pcierc_credit_chk: combinational class mux plus compare, returning a pass flag.

Test Plan:
- Posted write, desc_dw=4, 12 words, ph=5, pd=2 -> tx_req until tx_rdy; tx_st one cycle after grant; 12 contiguous words; tx_end on word 12; tlp_cnt=1.
- Completion, desc_dw=9, cpld=2 for 50 cycles, then raised to 3 -> no tx_req while blocked; stall_cnt=50; TLP then sends normally.
- Non-posted read, desc_dw=0, npd=0, nph=1 -> passes; 6-word header sent; tx_st on word 1, tx_end on word 6.
- pd=13'h1000 (infinite) with desc_dw=1024 -> no stall; stall_cnt stays 0.
- s_valid dropped at word 5 of 10 -> tx_end=tx_nlfy=1 on the next cycle with data 0; err_underrun=1; remaining words drained; tlp_cnt unchanged.
- desc_class=3 -> err_desc=1; packet drained; tx_req never asserted. Also rst_n pulsed in STREAM -> all outputs 0 immediately.
